// File: rtl/addr_router_arbiter.sv
// Round-robin arbiter with address decode. It forwards one request at a time to the selected slave,
// or completes the request locally with an error response on a decode miss.
package addr_router_arbiter_pkg;
  // Bounds are 64 bits wide so that one rule type can serve any ADDR_WIDTH up to 64.
  typedef struct packed {
    int unsigned slave_index;
    logic [63:0] lower_bound;
    logic [63:0] upper_bound;
  } addr_map_t;
endpackage

module addr_router_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_MST    = 4,
  parameter int NUM_SLV    = 4,
  parameter int NUM_RULES  = 4,
  parameter addr_router_arbiter_pkg::addr_map_t ADDR_MAP [NUM_RULES] = '{default: '0}
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MST-1:0]            m_valid_i,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] m_addr_i,
  output logic [NUM_MST-1:0]            m_ready_o,
  output logic [NUM_MST-1:0]            m_rsp_valid_o,
  output logic                          m_rsp_err_o,
  input  logic [NUM_MST-1:0]            m_rsp_ready_i,
  output logic [NUM_SLV-1:0]            s_valid_o,
  output logic [ADDR_WIDTH-1:0]         s_addr_o,
  input  logic [NUM_SLV-1:0]            s_ready_i,
  input  logic [NUM_SLV-1:0]            s_rsp_valid_i,
  output logic [NUM_SLV-1:0]            s_rsp_ready_o,
  output logic                          busy_o
);

  localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]            state;
  logic [MW-1:0]         last_grant;
  logic [MW-1:0]         grant;
  logic [SW-1:0]         slv;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  win_found;
  logic [MW-1:0]         win_idx;
  logic [MW-1:0]         cand;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  dec_hit;
  logic [SW-1:0]         dec_slv;

  // Round-robin search starts one past the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_MST; i++) begin
      cand = MW'((32'(last_grant) + i) % NUM_MST);
      if (!win_found && m_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int unsigned m = 0; m < NUM_MST; m++) begin
      if (MW'(m) == win_idx) win_addr = m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // The first matching rule wins, so lower rule indices take priority on overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_slv = '0;
    for (int unsigned r = 0; r < NUM_RULES; r++) begin
      if (!dec_hit && (64'(win_addr) >= ADDR_MAP[r].lower_bound)
                   && (64'(win_addr) <= ADDR_MAP[r].upper_bound)) begin
        dec_hit = 1'b1;
        dec_slv = SW'(ADDR_MAP[r].slave_index);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= MW'(NUM_MST - 1);
      grant      <= '0;
      slv        <= '0;
      addr_q     <= '0;
    end else begin
      case (state)
        IDLE: if (win_found) begin
          grant  <= win_idx;
          addr_q <= win_addr;
          slv    <= dec_slv;
          state  <= dec_hit ? REQ : ERR;
        end
        REQ: if (s_ready_i[slv]) state <= RSP;
        RSP: if (s_rsp_valid_i[slv] && m_rsp_ready_i[grant]) begin
          state      <= IDLE;
          last_grant <= grant;
        end
        ERR: if (m_rsp_ready_i[grant]) begin
          state      <= IDLE;
          last_grant <= grant;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_ready_o     = '0;
    m_rsp_valid_o = '0;
    m_rsp_err_o   = 1'b0;
    s_valid_o     = '0;
    s_addr_o      = '0;
    s_rsp_ready_o = '0;
    case (state)
      IDLE: if (win_found) m_ready_o[win_idx] = 1'b1;
      REQ: begin
        s_valid_o[slv] = 1'b1;
        s_addr_o       = addr_q;
      end
      RSP: begin
        m_rsp_valid_o[grant] = s_rsp_valid_i[slv];
        s_rsp_ready_o[slv]   = m_rsp_ready_i[grant];
      end
      ERR: begin
        m_rsp_valid_o[grant] = 1'b1;
        m_rsp_err_o          = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_addr_router_arbiter.sv
// Self-checking bench for addr_router_arbiter: directed and randomized transactions checked
// against a transaction-level reference (round-robin pick plus rule-table decode).
module tb_addr_router_arbiter;

  localparam int AW = 32;
  localparam int NM = 4;
  localparam int NS = 4;
  localparam int NR = 4;

  localparam addr_router_arbiter_pkg::addr_map_t MAP [NR] = '{
    '{slave_index: 1, lower_bound: 64'h0,         upper_bound: 64'hFF},
    '{slave_index: 3, lower_bound: 64'h80,        upper_bound: 64'h1FF},
    '{slave_index: 2, lower_bound: 64'h1000,      upper_bound: 64'h1FFF},
    '{slave_index: 0, lower_bound: 64'h8000_0000, upper_bound: 64'hFFFF_FFFF}
  };

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NM-1:0]    m_valid_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM-1:0]    m_ready_o;
  logic [NM-1:0]    m_rsp_valid_o;
  logic             m_rsp_err_o;
  logic [NM-1:0]    m_rsp_ready_i;
  logic [NS-1:0]    s_valid_o;
  logic [AW-1:0]    s_addr_o;
  logic [NS-1:0]    s_ready_i;
  logic [NS-1:0]    s_rsp_valid_i;
  logic [NS-1:0]    s_rsp_ready_o;
  logic             busy_o;

  addr_router_arbiter #(
    .ADDR_WIDTH(AW),
    .NUM_MST   (NM),
    .NUM_SLV   (NS),
    .NUM_RULES (NR),
    .ADDR_MAP  (MAP)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m_valid_i    (m_valid_i),
    .m_addr_i     (m_addr_i),
    .m_ready_o    (m_ready_o),
    .m_rsp_valid_o(m_rsp_valid_o),
    .m_rsp_err_o  (m_rsp_err_o),
    .m_rsp_ready_i(m_rsp_ready_i),
    .s_valid_o    (s_valid_o),
    .s_addr_o     (s_addr_o),
    .s_ready_i    (s_ready_i),
    .s_rsp_valid_i(s_rsp_valid_i),
    .s_rsp_ready_o(s_rsp_ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          vectors = 0;
  int          miscompares = 0;
  int          last_g = NM - 1;
  logic [31:0] addr_tab [NM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] mrdy, input logic [3:0] mrv,
                          input logic err, input logic [3:0] sv, input logic [31:0] saddr,
                          input logic [3:0] srr, input logic busy);
    chk({tag, ".m_ready"},     64'(m_ready_o),     64'(mrdy));
    chk({tag, ".m_rsp_valid"}, 64'(m_rsp_valid_o), 64'(mrv));
    chk({tag, ".m_rsp_err"},   64'(m_rsp_err_o),   64'(err));
    chk({tag, ".s_valid"},     64'(s_valid_o),     64'(sv));
    chk({tag, ".s_addr"},      64'(s_addr_o),      64'(saddr));
    chk({tag, ".s_rsp_ready"}, 64'(s_rsp_ready_o), 64'(srr));
    chk({tag, ".busy"},        64'(busy_o),        64'(busy));
  endtask

  function automatic logic [3:0] bit_of(input int i);
    return 4'(1) << i;
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int last);
    for (int k = 1; k <= NM; k++) if (mask[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  task automatic ref_decode(input logic [31:0] a, output bit hit, output int slv);
    hit = 1'b0;
    slv = 0;
    for (int r = 0; r < NR; r++) begin
      if (!hit && 64'(a) >= MAP[r].lower_bound && 64'(a) <= MAP[r].upper_bound) begin
        hit = 1'b1;
        slv = int'(MAP[r].slave_index);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 8))
      0: return 32'h90;
      1: return 32'h1FF;
      2: return 32'h1000;
      3: return 32'h1FFF;
      4: return 32'hFF;
      5: return 32'h80;
      6: return 32'($urandom_range(32'h200, 32'hFFF));
      7: return 32'h2000;
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_inputs();
    m_valid_i = '0;
    m_addr_i = '0;
    m_rsp_ready_i = '0;
    s_ready_i = '0;
    s_rsp_valid_i = '0;
  endtask

  task automatic do_abort(input string tag);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_inputs();
    #1;
    chk_outs(tag, 0, 0, 0, 0, 0, 0, 0);
    last_g = NM - 1;
  endtask

  // abort: 0 = complete normally, 1 = reset during REQ, 2 = reset during RSP
  task automatic run_txn(input logic [3:0] mask, input int s_stall, input int v_stall,
                         input int r_stall, input int abort);
    int g, slv, hs, last;
    bit hit;
    logic [31:0] a;
    g = rr_pick(mask, last_g);
    a = addr_tab[g];
    ref_decode(a, hit, slv);
    m_valid_i = mask;
    for (int i = 0; i < NM; i++) m_addr_i[i*AW +: AW] = addr_tab[i];
    s_ready_i = '0;
    s_rsp_valid_i = 4'($urandom);
    m_rsp_ready_i = 4'($urandom);
    #1;
    chk_outs("idle", bit_of(g), 0, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    m_valid_i[g] = 1'b0;
    hs = 0;
    if (hit) begin
      for (int c = 0; c <= s_stall; c++) begin
        s_ready_i = 4'($urandom) & ~bit_of(slv);
        if (c == s_stall) s_ready_i[slv] = 1'b1;
        s_rsp_valid_i = 4'($urandom);
        m_rsp_ready_i = 4'($urandom);
        #1;
        chk_outs("req", 0, 0, 0, bit_of(slv), a, 0, 1);
        if (abort == 1 && c == s_stall) begin
          do_abort("rst_in_req");
          return;
        end
        @(posedge clk_i); #1;
      end
      s_ready_i = '0;
      last = v_stall + r_stall;
      for (int c = 0; c <= last; c++) begin
        s_rsp_valid_i = 4'($urandom);
        s_rsp_valid_i[slv] = (c >= v_stall);
        m_rsp_ready_i = 4'($urandom);
        if (c >= v_stall) m_rsp_ready_i[g] = (c == last);
        #1;
        chk_outs("rsp", 0, s_rsp_valid_i[slv] ? bit_of(g) : 4'b0, 0, 0, 0,
                 m_rsp_ready_i[g] ? bit_of(slv) : 4'b0, 1);
        if (m_rsp_valid_o[g] && m_rsp_ready_i[g]) hs++;
        if (abort == 2 && c == last) begin
          do_abort("rst_in_rsp");
          return;
        end
        @(posedge clk_i); #1;
      end
    end else begin
      for (int c = 0; c <= r_stall; c++) begin
        s_rsp_valid_i = 4'($urandom);
        s_ready_i = 4'($urandom);
        m_rsp_ready_i = 4'($urandom);
        m_rsp_ready_i[g] = (c == r_stall);
        #1;
        chk_outs("err", 0, bit_of(g), 1, 0, 0, 0, 1);
        if (m_rsp_valid_o[g] && m_rsp_ready_i[g]) hs++;
        @(posedge clk_i); #1;
      end
    end
    last_g = g;
    chk("handshakes", 64'(hs), 64'd1);
    clear_inputs();
    #1;
    chk_outs("done", 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);

    // all requesters always valid, no stalls: grants rotate 0,1,2,3,0
    addr_tab = '{32'h1000, 32'h90, 32'h1FF, 32'h8000_0000};
    for (int k = 0; k < 5; k++) run_txn(4'hF, 0, 0, 0, 0);

    // directed decode cases: rule hit, overlap priority, upper bound, miss
    addr_tab = '{32'h1000, 32'h1000, 32'h1000, 32'h1000};
    run_txn(4'h1, 0, 0, 0, 0);
    addr_tab = '{32'h90, 32'h90, 32'h90, 32'h90};
    run_txn(4'h2, 0, 0, 0, 0);
    addr_tab = '{32'h1FF, 32'h1FF, 32'h1FF, 32'h1FF};
    run_txn(4'h4, 0, 0, 0, 0);
    addr_tab = '{32'h500, 32'h500, 32'h500, 32'h500};
    run_txn(4'h8, 0, 0, 3, 0);
    addr_tab = '{32'h2000, 32'h7FFF_FFFF, 32'h200, 32'hFFF};
    run_txn(4'hF, 0, 0, 0, 0);

    // slave stalls request 5 cycles, response held while requester stalls 3 cycles
    addr_tab = '{32'h1800, 32'h1800, 32'h1800, 32'h1800};
    run_txn(4'h4, 5, 0, 3, 0);
    run_txn(4'h5, 2, 2, 2, 0);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NM; i++) addr_tab[i] = rand_addr();
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 0);
    end

    // reset mid-transaction, then the next grant restarts from requester 0
    addr_tab = '{32'h1000, 32'h90, 32'h1FF, 32'h8000_0000};
    run_txn(4'h6, 2, 0, 0, 1);
    run_txn(4'hF, 0, 0, 0, 0);
    run_txn(4'hC, 0, 1, 1, 2);
    run_txn(4'hF, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
